// File: rtl/full_mat_chain_if.sv
// Handshake and matrix bus for full_mat_chain: start/link matrices in, status and prefix products out.
interface full_mat_chain_if #(
  parameter int unsigned N_LINKS = 6,
  parameter int unsigned W       = 27
);
  localparam int unsigned BW = N_LINKS * 3 * 4 * W;

  logic          start;
  logic [BW-1:0] link_mat;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic          sat;
  logic [BW-1:0] full_matrix;

  modport master (
    output start, link_mat,
    input  busy, done, out_valid, sat, full_matrix
  );

  modport slave (
    input  start, link_mat,
    output busy, done, out_valid, sat, full_matrix
  );
endinterface

// File: rtl/full_mat_chain.sv
// Forward-kinematics prefix products T_k = A_0*...*A_k on LANES time-multiplexed fixed-point multipliers.
// Define FULL_MAT_CHAIN_ROUND_EN to round each product term to nearest instead of truncating.
module full_mat_chain #(
  parameter int unsigned N_LINKS = 6,
  parameter int unsigned W       = 27,
  parameter int unsigned FRAC    = 16,
  parameter int unsigned LANES   = 4
) (
  input logic             clk,
  input logic             rst,
  full_mat_chain_if.slave bus
);

  localparam int unsigned G_N = 12 / LANES;
  localparam int unsigned KW  = (N_LINKS > 1) ? $clog2(N_LINKS) : 1;
  localparam int unsigned GW  = (G_N > 1) ? $clog2(G_N) : 1;
  localparam int unsigned AW  = W + 3;
  localparam int unsigned FW  = W + 4;
  localparam int unsigned PW  = 2 * W;
  localparam int unsigned BW  = N_LINKS * 3 * 4 * W;

  typedef logic signed [W-1:0] elem_t;

  localparam elem_t MAXE = {1'b0, {(W-1){1'b1}}};
  localparam elem_t MINE = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [FW-1:0] MAXF = {{(FW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [FW-1:0] MINF = ~MAXF;
`ifdef FULL_MAT_CHAIN_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (FRAC - 1);
`endif

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t              state_q;
  logic [KW-1:0]       k_q;
  logic [GW-1:0]       g_q;
  logic [1:0]          t_q;
  logic                busy_q;
  logic                done_q;
  logic                valid_q;
  logic                sat_q;
  elem_t               fm_q  [N_LINKS][3][4];
  logic signed [AW-1:0] acc_q [LANES];

  elem_t               lm    [N_LINKS][3][4];
  logic [BW-1:0]       fm_flat;

  logic [KW-1:0]       km1;
  logic [1:0]          lane_i   [LANES];
  logic [1:0]          lane_j   [LANES];
  elem_t               op_a     [LANES];
  elem_t               op_b     [LANES];
  elem_t               bias     [LANES];
  logic signed [PW-1:0] prod    [LANES];
  logic signed [AW-1:0] term    [LANES];
  logic signed [FW-1:0] fin     [LANES];
  elem_t               wb_val   [LANES];
  logic                wb_clamp [LANES];

  always_comb begin
    fm_flat = '0;
    for (int unsigned k = 0; k < N_LINKS; k++) begin
      for (int unsigned i = 0; i < 3; i++) begin
        for (int unsigned j = 0; j < 4; j++) begin
          lm[k][i][j] = bus.link_mat[((k*3+i)*4+j)*W +: W];
          fm_flat[((k*3+i)*4+j)*W +: W] = fm_q[k][i][j];
        end
      end
    end
  end

  // Lane L of group g owns element e = g*LANES+L, i.e. row e/4, column e%4.
  always_comb begin
    km1 = (k_q == '0) ? '0 : k_q - KW'(1);
    for (int unsigned l = 0; l < LANES; l++) begin
      int unsigned e;
      e         = LANES * g_q + l;
      lane_i[l] = 2'(e / 4);
      lane_j[l] = 2'(e % 4);
      op_a[l]   = fm_q[km1][lane_i[l]][t_q];
      op_b[l]   = lm[k_q][t_q][lane_j[l]];
      prod[l]   = op_a[l] * op_b[l];
`ifdef FULL_MAT_CHAIN_ROUND_EN
      term[l]   = AW'((prod[l] + HALF) >>> FRAC);
`else
      term[l]   = AW'(prod[l] >>> FRAC);
`endif
      bias[l]   = '0;
      if (lane_j[l] == 2'd3) bias[l] = fm_q[km1][lane_i[l]][3];
      fin[l]    = FW'(acc_q[l]) + FW'(term[l]) + FW'(bias[l]);
      wb_clamp[l] = 1'b1;
      if (fin[l] > MAXF)      wb_val[l] = MAXE;
      else if (fin[l] < MINF) wb_val[l] = MINE;
      else begin
        wb_val[l]   = W'(fin[l]);
        wb_clamp[l] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      g_q     <= '0;
      t_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      fm_q    <= '{default: '0};
      acc_q   <= '{default: '0};
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            fm_q[0] <= lm[0];
            k_q     <= KW'(1);
            g_q     <= '0;
            t_q     <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b1;
            if (N_LINKS == 1) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= MULT;
            end
          end
        end

        MULT: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            if (t_q == 2'd0) begin
              acc_q[l] <= term[l];
            end else if (t_q == 2'd1) begin
              acc_q[l] <= acc_q[l] + term[l];
            end else begin
              fm_q[k_q][lane_i[l]][lane_j[l]] <= wb_val[l];
              if (wb_clamp[l]) sat_q <= 1'b1;
            end
          end
          // Rows of T_k are written in place; T_{k-1} is complete before k advances.
          if (t_q == 2'd2) begin
            t_q <= '0;
            if (g_q == GW'(G_N - 1)) begin
              g_q <= '0;
              if (k_q == KW'(N_LINKS - 1)) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                k_q <= k_q + KW'(1);
              end
            end else begin
              g_q <= g_q + GW'(1);
            end
          end else begin
            t_q <= t_q + 2'd1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.out_valid   = valid_q;
  assign bus.sat         = sat_q;
  assign bus.full_matrix = fm_flat;

endmodule

// File: tb/tb_full_mat_chain.sv
// Scoreboard bench for full_mat_chain: matrix-level reference model, directed and random chains.
module tb_full_mat_chain;

  localparam int unsigned N     = 6;
  localparam int unsigned W     = 27;
  localparam int unsigned FRAC  = 16;
  localparam int unsigned LANES = 4;
  localparam int unsigned BW    = N * 12 * W;
  localparam int          LAT   = (N - 1) * 36 / LANES;
  localparam longint      ONE   = 65536;

  logic clk = 1'b0;
  logic rst = 1'b0;

  full_mat_chain_if #(.N_LINKS(N), .W(W)) bus();

  full_mat_chain #(.N_LINKS(N), .W(W), .FRAC(FRAC), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [BW-1:0] exp_mat_q[$];
  bit            exp_sat_q[$];
  int            e0_q[$];
  logic [BW-1:0] lm_v;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic longint el(input logic [BW-1:0] v, input int k, input int i, input int j);
    logic signed [W-1:0] x;
    x = v[((k*3+i)*4+j)*W +: W];
    return longint'(x);
  endfunction

  function automatic void put(input int k, input int i, input int j, input longint val);
    logic [63:0] tmp;
    tmp = val;
    lm_v[((k*3+i)*4+j)*W +: W] = tmp[W-1:0];
  endfunction

  function automatic void identity_all();
    lm_v = '0;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 3; i++) put(k, i, i, ONE);
  endfunction

  // Reference: plain matrix product with an implicit [0 0 0 1] bottom row, saturated per element.
  function automatic void model(input logic [BW-1:0] m, output logic [BW-1:0] f, output bit s);
    longint t [N][3][4];
    longint p, acc, hi, lo;
    logic [63:0] tmp;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -hi - 1;
    s  = 1'b0;
    f  = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++) t[0][i][j] = el(m, 0, i, j);
    for (int k = 1; k < N; k++) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 4; j++) begin
          acc = (j == 3) ? t[k-1][i][3] : 0;
          for (int q = 0; q < 3; q++) begin
            p = t[k-1][i][q] * el(m, k, q, j);
`ifdef FULL_MAT_CHAIN_ROUND_EN
            acc += (p + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
`else
            acc += p >>> FRAC;
`endif
          end
          if (acc > hi) begin acc = hi; s = 1'b1; end
          if (acc < lo) begin acc = lo; s = 1'b1; end
          t[k][i][j] = acc;
        end
      end
    end
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 4; j++) begin
          tmp = t[k][i][j];
          f[((k*3+i)*4+j)*W +: W] = tmp[W-1:0];
        end
  endfunction

  // Monitor: every done pulse is matched against the oldest outstanding run.
  initial begin
    logic [BW-1:0] ef;
    bit es;
    int e0, bk, bi, bj;
    forever begin
      @(negedge clk);
      if (rst && bus.done) begin
        if (exp_mat_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          ef = exp_mat_q.pop_front();
          es = exp_sat_q.pop_front();
          e0 = e0_q.pop_front();
          chk("done_latency", cyc - e0, LAT);
          chk("busy_in_done", bus.busy, 1);
          chk("sat", bus.sat, es);
          bk = 0; bi = 0; bj = 0;
          for (int k = N - 1; k >= 0; k--)
            for (int i = 2; i >= 0; i--)
              for (int j = 3; j >= 0; j--)
                if (el(bus.full_matrix, k, i, j) != el(ef, k, i, j)) begin
                  bk = k; bi = i; bj = j;
                end
          chk($sformatf("T%0d[%0d][%0d]", bk, bi, bj),
              el(bus.full_matrix, bk, bi, bj), el(ef, bk, bi, bj));
          @(negedge clk);
          chk("valid_after_done", bus.out_valid, 1);
          chk("busy_cleared", bus.busy, 0);
          chk("done_one_cycle", bus.done, 0);
        end
      end
    end
  end

  task automatic run_case(input int inject_at);
    logic [BW-1:0] ef;
    bit es;
    bit seen;
    model(lm_v, ef, es);
    @(negedge clk);
    bus.link_mat = lm_v;
    bus.start    = 1'b1;
    exp_mat_q.push_back(ef);
    exp_sat_q.push_back(es);
    @(posedge clk);
    #1;
    e0_q.push_back(cyc);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    chk("valid_cleared", bus.out_valid, 0);
    if (inject_at > 0) begin
      repeat (inject_at - 1) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    if (!seen) chk("run_timeout", bus.out_valid, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_mid_run();
    logic [BW-1:0] ef;
    bit es;
    model(lm_v, ef, es);
    @(negedge clk);
    bus.link_mat = lm_v;
    bus.start    = 1'b1;
    exp_mat_q.push_back(ef);
    exp_sat_q.push_back(es);
    @(posedge clk);
    #1;
    e0_q.push_back(cyc);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sat", bus.sat, 0);
    chk("rst_matrix_ones", $countones(bus.full_matrix), 0);
    exp_mat_q.delete();
    exp_sat_q.delete();
    e0_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", bus.busy, 0);
  endtask

  task automatic randomize_links();
    lm_v = '0;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 4; j++)
          put(k, i, j, longint'(int'($urandom_range(0, 262144)) - 131072));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.link_mat = '0;
    lm_v         = '0;
    rst          = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_sat", bus.sat, 0);
    chk("reset_matrix_ones", $countones(bus.full_matrix), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    identity_all();
    run_case(0);

    identity_all();
    for (int k = 0; k < N; k++) put(k, 0, 3, ONE);
    run_case(0);

    lm_v = '0;
    for (int k = 0; k < N; k++) begin
      put(k, 0, 1, -ONE);
      put(k, 1, 0, ONE);
      put(k, 2, 2, ONE);
    end
    run_case(0);

    identity_all();
    for (int k = 0; k < N; k++) put(k, 0, 3, 33554432);
    run_case(0);

    identity_all();
    put(0, 0, 0, 3);
    put(1, 0, 0, 32768);
    run_case(0);

    identity_all();
    for (int k = 0; k < N; k++) put(k, 1, 3, -3 * ONE / 2);
    run_case(10);

    for (int r = 0; r < 8; r++) begin
      randomize_links();
      run_case(0);
    end

    randomize_links();
    reset_mid_run();

    for (int r = 0; r < 2; r++) begin
      randomize_links();
      run_case(0);
    end

    repeat (5) @(negedge clk);
    chk("outstanding_runs", exp_mat_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
